// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- architectural integer register file for the single-cycle core.
//
// 2**ADDR_W registers of DATA_W bits. x0 is hardwired to zero and has no
// storage behind it.
//
// Ports (positional order is fixed because parents connect positionally):
//   A1   in  ADDR_W  read address, port 1
//   A2   in  ADDR_W  read address, port 2
//   A3   in  ADDR_W  write address
//   RD1  out DATA_W  combinational read data for A1 (0 when A1 == 0)
//   RD2  out DATA_W  combinational read data for A2 (0 when A2 == 0)
//   WE3  in  1       write enable, active-high
//   WD3  in  DATA_W  write data
//   clk  in  1       clock; all state changes on the rising edge
//   rst  in  1       synchronous reset, active-low; clears every register
//
// Reads have no write-to-read bypass: during a write cycle the read ports
// show the old contents until the rising edge commits the new value.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              clk,
  input  logic              rst
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Read view of the register bank: entry 0 is a constant zero, entries
  // 1..DEPTH-1 are the flops. Every register needs a reset clear, so the
  // storage is built from flops rather than a RAM macro.
  logic [DATA_W-1:0] bank [DEPTH];

  // One-hot decoded write enable; bit 0 is never set so x0 writes vanish.
  logic [DEPTH-1:0] wr_en;

  always_comb begin
    wr_en = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (WE3 && (A3 == ADDR_W'(i))) begin
        wr_en[i] = 1'b1;
      end
    end
  end

  assign bank[0] = '0;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] data_reg;

      // Reset takes priority over a write in the same cycle.
      always_ff @(posedge clk) begin
        if (!rst) begin
          data_reg <= '0;
        end else if (wr_en[gi]) begin
          data_reg <= WD3;
        end
      end

      assign bank[gi] = data_reg;
    end
  endgenerate

  // Explicit DEPTH:1 read multiplexers. Address 0 selects the constant
  // zero entry, so x0 reads as 0 even before the first reset.
  always_comb begin
    RD1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (A1 == ADDR_W'(i)) begin
        RD1 = bank[i];
      end
    end
  end

  always_comb begin
    RD2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (A2 == ADDR_W'(i)) begin
        RD2 = bank[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file -- directed self-checking bench for reg_file.
// Expected values are pushed to a scoreboard queue as each step is driven
// and popped when the corresponding read data is sampled.
// ---------------------------------------------------------------------------
module tb_reg_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic [ADDR_W-1:0] A1, A2, A3;
  logic [DATA_W-1:0] RD1, RD2, WD3;
  logic              WE3, clk, rst;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] model [32];

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .A1 (A1),
    .A2 (A2),
    .A3 (A3),
    .RD1(RD1),
    .RD2(RD2),
    .WE3(WE3),
    .WD3(WD3),
    .clk(clk),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] exp);
    sb.push_back(exp);
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] observed);
    logic [DATA_W-1:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, observed);
    end else begin
      exp = sb.pop_front();
      assert (observed === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, exp);
      end
    end
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WE3 = 1'b0; rst = 1'b1;
    #2;

    // x0 reads zero even before any reset.
    push('0); check("x0_before_reset", RD1);

    // 1: reset held two edges with a write pending; reset wins.
    rst = 1'b0; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h12345678;
    tick(); tick();
    rst = 1'b1; WE3 = 1'b0; A1 = 5'd5; A2 = 5'd7;
    #1;
    push('0); check("reset_wins_rd1", RD1);
    push('0); check("reset_wins_rd2", RD2);
    for (int i = 0; i < 32; i++) model[i] = '0;

    // 2: write to x0 is discarded.
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hABCDABCD;
    tick();
    A1 = 5'd0; A2 = 5'd0;
    #1;
    push('0); check("x0_write_rd1", RD1);
    push('0); check("x0_write_rd2", RD2);

    // 3: last write wins, data persists.
    WE3 = 1'b1; A3 = 5'd1; WD3 = 32'h00000001; tick();
    A3 = 5'd5; WD3 = 32'hFFFF0000; tick();
    A3 = 5'd5; WD3 = 32'hADAD0000; tick();
    WE3 = 1'b0; A1 = 5'd5; A2 = 5'd1;
    #1;
    model[1] = 32'h00000001; model[5] = 32'hADAD0000;
    push(32'hADAD0000); check("last_write_rd1", RD1);
    push(32'h00000001); check("persist_rd2", RD2);

    // 4: WE3 low, nothing changes across three edges.
    WE3 = 1'b0; A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5;
    tick(); tick(); tick();
    push(32'hADAD0000); check("we_low_hold", RD1);

    // 5: read-during-write, no bypass; both ports agree.
    A1 = 5'd9; A2 = 5'd9; A3 = 5'd9; WE3 = 1'b1; WD3 = 32'hCAFEF00D;
    #1;
    push('0); check("rdw_before_rd1", RD1);
    push('0); check("rdw_before_rd2", RD2);
    tick();
    WE3 = 1'b0;
    model[9] = 32'hCAFEF00D;
    push(32'hCAFEF00D); check("rdw_after_rd1", RD1);
    push(32'hCAFEF00D); check("rdw_after_rd2", RD2);

    // Sweep: write a distinct value to every address (x0 included) and read
    // everything back through both ports in differing orders.
    for (int i = 0; i < 32; i++) begin
      v = (32'(i) * 32'h01010101) ^ 32'hA5000000 ^ (32'(i) << 27);
      WE3 = 1'b1; A3 = 5'(i); WD3 = v;
      tick();
      if (i != 0) model[i] = v;
    end
    WE3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      push(model[i]);      check($sformatf("sweep_rd1_x%0d", i), RD1);
      push(model[31 - i]); check($sformatf("sweep_rd2_x%0d", 31 - i), RD2);
    end

    // Reset has no effect between edges.
    A1 = 5'd1; A2 = 5'd5;
    rst = 1'b0; WE3 = 1'b1; A3 = 5'd2; WD3 = 32'h55555555;
    #1;
    push(model[1]); check("rst_no_async_rd1", RD1);
    push(model[5]); check("rst_no_async_rd2", RD2);

    // 6: reset mid-operation with a write pending clears everything.
    tick();
    rst = 1'b1; WE3 = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    A1 = 5'd1; A2 = 5'd2;
    #1;
    push('0); check("mid_reset_x1", RD1);
    push('0); check("mid_reset_x2", RD2);
    A1 = 5'd5;
    #1;
    push('0); check("mid_reset_x5", RD1);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      #1;
      push(model[i]); check($sformatf("mid_reset_sweep_x%0d", i), RD1);
    end

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
